// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: multi-cycle SLL/SRL/SRA sequencer using coarse and 1-bit shift steps
module shift_seq_ctrl #(
  parameter int WIDTH  = 32,
  parameter int SHW    = 5,
  parameter int COARSE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rt,
  input  logic [SHW-1:0]   shamt,
  input  logic             flush,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             err
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, nstate;
  logic [WIDTH-1:0] sr, nsr;
  logic [SHW-1:0] rem, nrem;
  logic [1:0] opr;
  logic acc, zero, big, fill, last;
  assign ready = state != SHIFT;
  assign busy  = state == SHIFT;
  // next state and one shift step; SRA refills from the register MSB, which stays the original sign
  always_comb begin
    acc    = ready & start & ~flush;
    zero   = shamt == '0 || op == 2'b11;
    big    = rem >= SHW'(COARSE);
    fill   = opr[1] & sr[WIDTH-1];
    nsr    = opr == 2'b00 ? (big ? {sr[WIDTH-COARSE-1:0], {COARSE{1'b0}}} : {sr[WIDTH-2:0], 1'b0})
                          : (big ? {{COARSE{fill}}, sr[WIDTH-1:COARSE]} : {fill, sr[WIDTH-1:1]});
    nrem   = rem - (big ? SHW'(COARSE) : SHW'(1));
    last   = nrem == '0;
    nstate = flush ? IDLE : acc ? (zero ? DONE : SHIFT) : state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
  end
  // state register
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= nstate;
  // operand capture, stepping and registered result/flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr   <= '0;
      rem  <= '0;
      opr  <= '0;
      res  <= '0;
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      done <= nstate == DONE;
      err  <= acc && op == 2'b11;
      if (acc) begin
        sr  <= rt;
        rem <= shamt;
        opr <= op;
        if (zero) res <= rt;
      end else if (state == SHIFT && !flush) begin
        sr  <= nsr;
        rem <= nrem;
        if (last) res <= nsr;
      end
    end
  end
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: table-driven and directed checks of the shift sequencer
module tb_shift_seq_ctrl;
  logic clk = 0, rst_n = 0, start = 0, flush = 0;
  logic [1:0] op = 0;
  logic [31:0] rt = 0;
  logic [4:0] shamt = 0;
  logic ready, busy, done, err;
  logic [31:0] res;
  int pass = 0, total = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rt;
    logic [4:0]  shamt;
    logic [31:0] res;
    logic        err;
    int          steps;
  } vec_t;
  vec_t tbl[9];

  shift_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rt(rt), .shamt(shamt),
    .flush(flush), .ready(ready), .busy(busy), .done(done), .res(res), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input vec_t v, input string nm);
    int n;
    start = 1; op = v.op; rt = v.rt; shamt = v.shamt;
    tick();
    start = 0;
    n = 1;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check({nm, " latency"}, n, v.steps + 1);
    check({nm, " res"}, res, v.res);
    check({nm, " err"}, {31'b0, err}, {31'b0, v.err});
  endtask

  initial begin
    int n, hits;
    tbl[0] = '{2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0, 10};
    tbl[1] = '{2'b10, 32'hF000_0000, 5'd5,  32'hFF80_0000, 1'b0, 2};
    tbl[2] = '{2'b10, 32'h7000_0000, 5'd5,  32'h0380_0000, 1'b0, 2};
    tbl[3] = '{2'b00, 32'h0000_0001, 5'd4,  32'h0000_0010, 1'b0, 1};
    tbl[4] = '{2'b00, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0, 0};
    tbl[5] = '{2'b11, 32'hDEAD_BEEF, 5'd7,  32'hDEAD_BEEF, 1'b1, 0};
    tbl[6] = '{2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 10};
    tbl[7] = '{2'b00, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 1'b0, 10};
    tbl[8] = '{2'b01, 32'h0000_FF00, 5'd8,  32'h0000_00FF, 1'b0, 2};

    tick();
    tick();
    check("reset res", res, 0);
    check("reset done", {31'b0, done}, 0);
    check("reset ready", {31'b0, ready}, 1);
    check("reset busy", {31'b0, busy}, 0);
    check("reset err", {31'b0, err}, 0);
    rst_n = 1;
    tick();

    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i], $sformatf("vec%0d", i));
      tick();
      check($sformatf("vec%0d done drop", i), {31'b0, done}, 0);
      check($sformatf("vec%0d idle ready", i), {31'b0, ready}, 1);
    end

    run_op(tbl[4], "b2b first");
    start = 1; op = 2'b01; rt = 32'h0000_FF00; shamt = 5'd8;
    tick();
    start = 0;
    check("b2b no gap busy", {31'b0, busy}, 1);
    check("b2b done low", {31'b0, done}, 0);
    tick();
    tick();
    check("b2b done", {31'b0, done}, 1);
    check("b2b res", res, 32'h0000_00FF);
    start = 1; op = 2'b11; rt = 32'hCAFE_F00D; shamt = 5'd3;
    tick();
    start = 0;
    check("b2b illegal done", {31'b0, done}, 1);
    check("b2b illegal err", {31'b0, err}, 1);
    check("b2b illegal res", res, 32'hCAFE_F00D);
    tick();
    check("b2b idle done", {31'b0, done}, 0);
    check("b2b idle err", {31'b0, err}, 0);

    start = 1; op = 2'b01; rt = 32'h8000_0000; shamt = 5'd31;
    tick();
    start = 0;
    check("flush busy", {31'b0, busy}, 1);
    tick();
    tick();
    flush = 1; start = 1; op = 2'b00; rt = 32'h1; shamt = 5'd0;
    tick();
    flush = 0; start = 0;
    check("flush ready", {31'b0, ready}, 1);
    check("flush busy low", {31'b0, busy}, 0);
    check("flush done low", {31'b0, done}, 0);
    check("flush res kept", res, 32'hCAFE_F00D);
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) hits++;
    end
    check("flush no activity", hits, 0);

    start = 1; op = 2'b10; rt = 32'hF000_0000; shamt = 5'd31;
    tick();
    start = 0;
    n = 1;
    tick();
    n++;
    start = 1; op = 2'b00; rt = 32'h1; shamt = 5'd1;
    tick();
    n++;
    start = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check("busy start latency", n, 11);
    check("busy start res", res, 32'hFFFF_FFFF);
    tick();

    start = 1; op = 2'b01; rt = 32'h8000_0000; shamt = 5'd31;
    tick();
    start = 0;
    tick();
    tick();
    rst_n = 0;
    tick();
    check("midrst res", res, 0);
    check("midrst ready", {31'b0, ready}, 1);
    check("midrst busy", {31'b0, busy}, 0);
    check("midrst done", {31'b0, done}, 0);
    rst_n = 1;
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) hits++;
    end
    check("midrst no done", hits, 0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
